// File: rtl/ula_pkg.sv
// Shared opcodes, FSM state and iteration-mode types for the sequential ALU.
package ula_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } ula_state_e;

  typedef enum logic {
    ModeMul,
    ModeDiv
  } iter_mode_e;

endpackage

// File: rtl/ula_iter_core.sv
// Iterative engine: shift-add multiply or restoring divide, one step per cycle for WIDTH cycles.
// res_o is the {acc, shift} value after the step taken this cycle, i.e. valid on the done edge.
module ula_iter_core
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  iter_mode_e         mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  iter_mode_e       mode_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic             ge;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, opnd_q};
    rem_sh = {acc_q, sh_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, opnd_q});
    acc_d  = acc_q;
    sh_d   = sh_q;
    if (mode_q == ModeMul) begin
      // Add multiplicand into the high half when the multiplier LSB is set, then shift right.
      if (sh_q[0]) begin
        acc_d = sum[WIDTH:1];
        sh_d  = {sum[0], sh_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[WIDTH-1:1]};
        sh_d  = {acc_q[0], sh_q[WIDTH-1:1]};
      end
    end else begin
      acc_d = ge ? WIDTH'(rem_sh - {1'b0, opnd_q}) : rem_sh[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], ge};
    end
  end

  assign busy_o = busy_q;
  assign done_o = (cnt_q == CW'(WIDTH - 1));
  assign res_o  = {acc_d, sh_d};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= ModeMul;
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      mode_q <= mode_i;
      acc_q  <= '0;
      sh_q   <= a_i;
      opnd_q <= b_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_seq_param.sv
// Handshaked sequential ALU: 1-cycle logic/add/sub, iterative mul/div via ula_iter_core.
// Optional macro ULA_SIGNED_EN: two's-complement mul/div with one extra sign-fix cycle.
module ula_seq_param
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OP_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OP_W-1:0]    op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_ula,
  output logic               sinal,
  output logic               zero,
  output logic               err
);

  localparam int unsigned RW = 2 * WIDTH;

  ula_state_e       state_q;
  logic [RW-1:0]    out_ula_q;
  logic             sinal_q, zero_q, err_q;

  logic             accept, is_iter, b_zero;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [RW-1:0]    alu_res;
  logic             alu_sinal, alu_err;
  logic [WIDTH-1:0] core_a, core_b;
  iter_mode_e       core_mode;
  logic             core_busy, core_done;
  logic [RW-1:0]    core_res;

  assign in_ready  = (state_q == StIdle) & ~rst;
  assign accept    = in_valid & in_ready;
  assign b_zero    = (b == '0);
  assign is_iter   = (op == OP_MUL) | ((op == OP_DIV) & ~b_zero);
  assign core_mode = (op == OP_DIV) ? ModeDiv : ModeMul;

  assign out_valid = (state_q == StDone);
  assign out_ula   = out_ula_q;
  assign sinal     = sinal_q;
  assign zero      = zero_q;
  assign err       = err_q;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = a - b;
    alu_res   = '0;
    alu_sinal = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_ADD: alu_res = RW'(sum);
      OP_SUB: begin
        alu_res = RW'(diff);
`ifdef ULA_SIGNED_EN
        alu_sinal = ($signed(a) < $signed(b));
`else
        alu_sinal = (a < b);
`endif
      end
      OP_AND: alu_res = RW'(a & b);
      OP_OR:  alu_res = RW'(a | b);
      OP_XOR: alu_res = RW'(a ^ b);
      // Only reached as a single-cycle op when the divisor is zero.
      OP_DIV: begin
        alu_res = {a, {WIDTH{1'b1}}};
        alu_err = 1'b1;
      end
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ULA_SIGNED_EN
  logic             a_neg, b_neg;
  logic             fix_q, div_q, qneg_q, rneg_q;
  logic [RW-1:0]    mag_q, fix_res;
  logic [WIDTH-1:0] quot, rem;
  logic             fix_sinal;

  assign a_neg  = a[WIDTH-1];
  assign b_neg  = b[WIDTH-1];
  assign core_a = a_neg ? -a : a;
  assign core_b = b_neg ? -b : b;

  always_comb begin
    quot    = qneg_q ? -mag_q[WIDTH-1:0] : mag_q[WIDTH-1:0];
    rem     = rneg_q ? -mag_q[RW-1:WIDTH] : mag_q[RW-1:WIDTH];
    fix_res = div_q ? {rem, quot} : (qneg_q ? -mag_q : mag_q);
    // For div the sign reported is that of the quotient.
    fix_sinal = div_q ? fix_res[WIDTH-1] : fix_res[RW-1];
  end
`else
  assign core_a = a;
  assign core_b = b;
`endif

  ula_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(accept & is_iter),
    .mode_i (core_mode),
    .a_i    (core_a),
    .b_i    (core_b),
    .busy_o (core_busy),
    .done_o (core_done),
    .res_o  (core_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      out_ula_q <= '0;
      sinal_q   <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ULA_SIGNED_EN
      fix_q     <= 1'b0;
      div_q     <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      mag_q     <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_iter) begin
              state_q <= StCalc;
`ifdef ULA_SIGNED_EN
              fix_q   <= 1'b0;
              div_q   <= (op == OP_DIV);
              qneg_q  <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
`endif
            end else begin
              state_q   <= StDone;
              out_ula_q <= alu_res;
              sinal_q   <= alu_sinal;
              zero_q    <= (alu_res == '0);
              err_q     <= alu_err;
            end
          end
        end
        StCalc: begin
`ifdef ULA_SIGNED_EN
          if (fix_q) begin
            state_q   <= StDone;
            fix_q     <= 1'b0;
            out_ula_q <= fix_res;
            sinal_q   <= fix_sinal;
            zero_q    <= (fix_res == '0);
            err_q     <= 1'b0;
          end else if (core_busy && core_done) begin
            mag_q <= core_res;
            fix_q <= 1'b1;
          end
`else
          if (core_busy && core_done) begin
            state_q   <= StDone;
            out_ula_q <= core_res;
            sinal_q   <= 1'b0;
            zero_q    <= (core_res == '0);
            err_q     <= 1'b0;
          end
`endif
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq_param.sv
// Directed bench for ula_seq_param (WIDTH=4); signed-build vectors selected by ULA_SIGNED_EN.
module tb_ula_seq_param;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned OP_W  = 4;
`ifdef ULA_SIGNED_EN
  localparam int IterLat = WIDTH + 2;
`else
  localparam int IterLat = WIDTH + 1;
`endif

  logic               clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic               sinal, zero, err;
  logic [WIDTH-1:0]   a, b;
  logic [OP_W-1:0]    op;
  logic [2*WIDTH-1:0] out_ula;

  int checks = 0;
  int errors = 0;

  ula_seq_param #(
    .WIDTH(WIDTH),
    .OP_W (OP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ula  (out_ula),
    .sinal    (sinal),
    .zero     (zero),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one op, then count negedges until out_valid; in_ready must stay low meanwhile.
  task automatic issue(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic [OP_W-1:0] top, input int lat);
    int k;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 1);
    a = ta;
    b = tb;
    op = top;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'h5;
    b = 4'h6;
    op = 4'b0110;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
      chk({tag, "_busy"}, 32'(in_ready), 0);
    end
    chk({tag, "_lat"}, 32'(k), 32'(lat));
  endtask

  task automatic res(input string tag, input logic [2*WIDTH-1:0] eu, input logic es,
                     input logic ez, input logic ee);
    chk({tag, "_ula"}, 32'(out_ula), 32'(eu));
    chk({tag, "_sinal"}, 32'(sinal), 32'(es));
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    chk({tag, "_err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    op = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    issue("add", 4'd9, 4'd8, 4'b0001, 1);
    res("add", 8'h11, 1'b0, 1'b0, 1'b0);
    issue("sub", 4'd3, 4'd5, 4'b0010, 1);
    res("sub", 8'h0E, 1'b1, 1'b0, 1'b0);
    issue("xor", 4'hA, 4'hA, 4'b0110, 1);
    res("xor", 8'h00, 1'b0, 1'b1, 1'b0);
    issue("and", 4'hC, 4'h6, 4'b0100, 1);
    res("and", 8'h04, 1'b0, 1'b0, 1'b0);

`ifdef ULA_SIGNED_EN
    issue("smul", 4'h9, 4'h3, 4'b0011, IterLat);
    res("smul", 8'hEB, 1'b1, 1'b0, 1'b0);
    issue("sdiv", 4'h9, 4'h2, 4'b0111, IterLat);
    res("sdiv", 8'hFD, 1'b1, 1'b0, 1'b0);
`else
    issue("mul", 4'd15, 4'd15, 4'b0011, IterLat);
    res("mul", 8'hE1, 1'b0, 1'b0, 1'b0);
    issue("div", 4'd13, 4'd4, 4'b0111, IterLat);
    res("div", 8'h13, 1'b0, 1'b0, 1'b0);
`endif
    issue("div0", 4'd7, 4'd0, 4'b0111, 1);
    res("div0", 8'h7F, 1'b0, 1'b0, 1'b1);

    // Backpressure: result must hold and new requests be ignored while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    issue("bp", 4'hC, 4'h3, 4'b0101, 1);
    res("bp", 8'h0F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 4'h1;
      b = 4'h1;
      op = 4'b0001;
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_ready", 32'(in_ready), 0);
      chk("bp_hold_ula", 32'(out_ula), 32'h0F);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_ready", 32'(in_ready), 1);
    chk("bp_rel_valid", 32'(out_valid), 0);
    chk("bp_rel_ula", 32'(out_ula), 32'h0F);

    issue("illegal", 4'h3, 4'h3, 4'b1111, 1);
    res("illegal", 8'h00, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a multiply aborts it.
    @(negedge clk);
    a = 4'd15;
    b = 4'd15;
    op = 4'b0011;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(in_ready), 0);
    chk("mrst_valid", 32'(out_valid), 0);
    repeat (3) begin
      @(negedge clk);
      chk("mrst_hold_valid", 32'(out_valid), 0);
      chk("mrst_hold_ready", 32'(in_ready), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rel_ready", 32'(in_ready), 1);
    chk("mrst_rel_valid", 32'(out_valid), 0);
    issue("add2", 4'd1, 4'd1, 4'b0001, 1);
    res("add2", 8'h02, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
